// File: rtl/uart_fifo_bridge.sv
// Purpose: byte bridge between a UART core and a processor wrapper, one FIFO per direction.
// Latency: RX byte visible on rx_valid/rx_data two edges after the strobe edge; TX strobe two edges after the write edge.
// Backpressure: full FIFOs drop the incoming byte and set a sticky overflow flag; core_tx_stb holds until core_tx_ack.
//
// Ports:
//   clk_sys, RESET                 - system clock, synchronous active-high reset
//   core_rx_data/stb, core_rx_ack  - UART core receive side (level strobe, one-cycle ack pulse)
//   core_tx_data/stb, core_tx_ack  - UART core transmit side (request held until accepted)
//   tx_data/valid, tx_ready        - wrapper write port (rising edge of tx_valid = one byte)
//   rx_data/valid, rx_ack          - wrapper read port, first-word-fall-through (rising edge of rx_ack = pop)
//   clear_flags, rx/tx_overflow    - sticky drop flags and their clear
//   rx_count                       - RX FIFO occupancy
module uart_fifo_bridge #(
    parameter int DEPTH = 16
) (
    input  logic                       clk_sys,
    input  logic                       RESET,
    input  logic [7:0]                 core_rx_data,
    input  logic                       core_rx_stb,
    output logic                       core_rx_ack,
    output logic [7:0]                 core_tx_data,
    output logic                       core_tx_stb,
    input  logic                       core_tx_ack,
    input  logic [7:0]                 tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic [7:0]                 rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ack,
    input  logic                       clear_flags,
    output logic                       rx_overflow,
    output logic                       tx_overflow,
    output logic [$clog2(DEPTH):0]     rx_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic             rx_stb_q, tx_valid_q, rx_ack_q;
    logic [7:0]       rx_mem [DEPTH];
    logic [7:0]       tx_mem [DEPTH];
    logic [AW-1:0]    rx_wptr, rx_rptr, tx_wptr, tx_rptr;
    logic [CW-1:0]    rx_cnt, tx_cnt, rx_cnt_nxt, tx_cnt_nxt;
    logic [1:0]       tx_state;

    logic rx_rise, tx_rise, ack_rise;
    logic rx_push, rx_pop, rx_drop;
    logic tx_push, tx_pop, tx_drop;

    always_comb begin
        rx_rise  = core_rx_stb & ~rx_stb_q;
        tx_rise  = tx_valid & ~tx_valid_q;
        ack_rise = rx_ack & ~rx_ack_q;

        // A pop in the same cycle frees the slot a full FIFO's push needs.
        rx_pop  = ack_rise & (rx_cnt != '0);
        rx_push = rx_rise & ((rx_cnt != CNT_FULL) | rx_pop);
        rx_drop = rx_rise & ~rx_push;

        tx_pop  = (tx_state == ST_SEND) & core_tx_ack;
        tx_push = tx_rise & ((tx_cnt != CNT_FULL) | tx_pop);
        tx_drop = tx_rise & ~tx_push;

        rx_cnt_nxt = rx_cnt;
        if (rx_push & ~rx_pop) rx_cnt_nxt = rx_cnt + CNT_ONE;
        else if (~rx_push & rx_pop) rx_cnt_nxt = rx_cnt - CNT_ONE;

        tx_cnt_nxt = tx_cnt;
        if (tx_push & ~tx_pop) tx_cnt_nxt = tx_cnt + CNT_ONE;
        else if (~tx_push & tx_pop) tx_cnt_nxt = tx_cnt - CNT_ONE;
    end

    // Storage needs no reset: occupancy counters define which slots are live.
    always_ff @(posedge clk_sys) begin
        if (!RESET && rx_push) rx_mem[rx_wptr] <= core_rx_data;
        if (!RESET && tx_push) tx_mem[tx_wptr] <= tx_data;
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            rx_stb_q     <= 1'b0;
            tx_valid_q   <= 1'b0;
            rx_ack_q     <= 1'b0;
            rx_wptr      <= '0;
            rx_rptr      <= '0;
            tx_wptr      <= '0;
            tx_rptr      <= '0;
            rx_cnt       <= '0;
            tx_cnt       <= '0;
            tx_state     <= ST_IDLE;
            core_rx_ack  <= 1'b0;
            core_tx_stb  <= 1'b0;
            core_tx_data <= 8'h00;
            rx_valid     <= 1'b0;
            rx_data      <= 8'h00;
            rx_count     <= '0;
            rx_overflow  <= 1'b0;
            tx_overflow  <= 1'b0;
            tx_ready     <= 1'b1;
        end else begin
            rx_stb_q   <= core_rx_stb;
            tx_valid_q <= tx_valid;
            rx_ack_q   <= rx_ack;

            // Ack every strobe edge, stored or dropped, so the core never stalls.
            core_rx_ack <= rx_rise;

            if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
            if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
            if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
            if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
            rx_cnt <= rx_cnt_nxt;
            tx_cnt <= tx_cnt_nxt;

            // Wrapper-facing RX view trails the FIFO state by one edge.
            rx_valid <= (rx_cnt != '0);
            rx_count <= rx_cnt;
            if (rx_cnt != '0) rx_data <= rx_mem[rx_rptr];

            tx_ready <= (tx_cnt_nxt != CNT_FULL);

            // Overflow in the same cycle beats clear_flags.
            if (rx_drop)          rx_overflow <= 1'b1;
            else if (clear_flags) rx_overflow <= 1'b0;
            if (tx_drop)          tx_overflow <= 1'b1;
            else if (clear_flags) tx_overflow <= 1'b0;

            case (tx_state)
                ST_IDLE: begin
                    if (tx_cnt != '0) begin
                        core_tx_data <= tx_mem[tx_rptr];
                        core_tx_stb  <= 1'b1;
                        tx_state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (core_tx_ack) begin
                        core_tx_stb <= 1'b0;
                        tx_state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    tx_state <= ST_IDLE;
                end
                default: begin
                    core_tx_stb <= 1'b0;
                    tx_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Purpose: self-checking bench for uart_fifo_bridge: queue-based reference model plus directed literal checks.
// Latency: model predicts every output each cycle; inputs change 2 time units after the rising edge.
// Backpressure: random phases over-fill both FIFOs to exercise drop and simultaneous push/pop paths.
module tb_uart_fifo_bridge;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk_sys;
    logic          RESET;
    logic [7:0]    core_rx_data;
    logic          core_rx_stb;
    logic          core_rx_ack;
    logic [7:0]    core_tx_data;
    logic          core_tx_stb;
    logic          core_tx_ack;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ack;
    logic          clear_flags;
    logic          rx_overflow;
    logic          tx_overflow;
    logic [CW-1:0] rx_count;

    uart_fifo_bridge #(.DEPTH(DEPTH)) dut (
        .clk_sys      (clk_sys),
        .RESET        (RESET),
        .core_rx_data (core_rx_data),
        .core_rx_stb  (core_rx_stb),
        .core_rx_ack  (core_rx_ack),
        .core_tx_data (core_tx_data),
        .core_tx_stb  (core_tx_stb),
        .core_tx_ack  (core_tx_ack),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ack       (rx_ack),
        .clear_flags  (clear_flags),
        .rx_overflow  (rx_overflow),
        .tx_overflow  (tx_overflow),
        .rx_count     (rx_count)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #2;
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    int         phase;          // 0 idle, 1 request outstanding, 2 gap
    bit         model_live = 0;
    bit         m_prev_stb, m_prev_valid, m_prev_ack;
    bit         e_rx_ack, e_stb, e_rxv, e_rxo, e_txo, e_rdy;
    logic [7:0] e_txd, e_rxd;
    int         e_rxc;
    int         ms;
    bit         rs, rv, ra, popok, pushok, fpop;

    always @(posedge clk_sys) begin
        if (RESET) begin
            rxq.delete();
            txq.delete();
            phase = 0;
            m_prev_stb = 0; m_prev_valid = 0; m_prev_ack = 0;
            e_rx_ack = 0; e_stb = 0; e_txd = 8'h00;
            e_rxv = 0; e_rxd = 8'h00; e_rxc = 0;
            e_rxo = 0; e_txo = 0; e_rdy = 1;
            model_live = 1;
        end else begin
            rs = core_rx_stb && !m_prev_stb;
            rv = tx_valid && !m_prev_valid;
            ra = rx_ack && !m_prev_ack;

            // RX: wrapper view reflects the queue as it stood before this edge.
            e_rx_ack = rs;
            ms = rxq.size();
            e_rxv = (ms != 0);
            e_rxc = ms;
            if (ms != 0) e_rxd = rxq[0];
            popok  = ra && (ms > 0);
            pushok = rs && ((ms < DEPTH) || popok);
            if (popok)  void'(rxq.pop_front());
            if (pushok) rxq.push_back(core_rx_data);
            if (rs && !pushok)    e_rxo = 1;
            else if (clear_flags) e_rxo = 0;

            // TX: head byte offered to the core, removed only on its ack.
            ms = txq.size();
            fpop   = (phase == 1) && core_tx_ack;
            pushok = rv && ((ms < DEPTH) || fpop);
            if (phase == 0) begin
                if (ms != 0) begin
                    e_txd = txq[0];
                    e_stb = 1;
                    phase = 1;
                end
            end else if (phase == 1) begin
                if (core_tx_ack) begin
                    e_stb = 0;
                    phase = 2;
                end
            end else begin
                phase = 0;
            end
            if (fpop)   void'(txq.pop_front());
            if (pushok) txq.push_back(tx_data);
            if (rv && !pushok)    e_txo = 1;
            else if (clear_flags) e_txo = 0;
            e_rdy = (txq.size() < DEPTH);

            m_prev_stb   = core_rx_stb;
            m_prev_valid = tx_valid;
            m_prev_ack   = rx_ack;
        end
    end

    always @(negedge clk_sys) begin
        if (model_live) begin
            chk("core_rx_ack",  core_rx_ack,  e_rx_ack);
            chk("core_tx_stb",  core_tx_stb,  e_stb);
            chk("core_tx_data", core_tx_data, e_txd);
            chk("rx_valid",     rx_valid,     e_rxv);
            chk("rx_count",     rx_count,     e_rxc);
            chk("rx_overflow",  rx_overflow,  e_rxo);
            chk("tx_overflow",  tx_overflow,  e_txo);
            chk("tx_ready",     tx_ready,     e_rdy);
            if (e_rxv) chk("rx_data", rx_data, e_rxd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic rx_byte(input logic [7:0] b);
        core_rx_data = b;
        core_rx_stb  = 1'b1;
        tick(1);
        chk("lit_rx_ack_pulse", core_rx_ack, 1);
        core_rx_stb = 1'b0;
        tick(1);
        chk("lit_rx_ack_single", core_rx_ack, 0);
    endtask

    task automatic rx_pop();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        tick(1);
    endtask

    task automatic tx_write(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(1);
    endtask

    initial begin
        #900000;
        n_fail++;
        $display("FAIL timeout: bench did not complete within time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        logic [7:0] last;
        int         hits;
        bit         found;

        RESET = 1'b1;
        core_rx_data = 8'h00; core_rx_stb = 1'b0; core_tx_ack = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; rx_ack = 1'b0; clear_flags = 1'b0;
        tick(3);

        chk("rst_core_rx_ack",  core_rx_ack,  0);
        chk("rst_core_tx_stb",  core_tx_stb,  0);
        chk("rst_core_tx_data", core_tx_data, 0);
        chk("rst_rx_valid",     rx_valid,     0);
        chk("rst_rx_data",      rx_data,      0);
        chk("rst_rx_count",     rx_count,     0);
        chk("rst_rx_overflow",  rx_overflow,  0);
        chk("rst_tx_overflow",  tx_overflow,  0);
        chk("rst_tx_ready",     tx_ready,     1);
        RESET = 1'b0;
        tick(1);

        // Three received bytes, read back in order.
        rx_byte(8'h41); rx_byte(8'h42); rx_byte(8'h43);
        chk("lit_rx3_valid", rx_valid, 1);
        chk("lit_rx3_data",  rx_data,  8'h41);
        chk("lit_rx3_count", rx_count, 3);
        rx_pop();
        chk("lit_rx_pop1", rx_data, 8'h42);
        rx_pop();
        chk("lit_rx_pop2", rx_data, 8'h43);
        rx_pop();
        chk("lit_rx_empty", rx_valid, 0);

        // DEPTH+1 bytes: last one dropped, overflow raised then cleared.
        for (int i = 0; i < DEPTH + 1; i++) rx_byte(8'(i + 1));
        chk("lit_rxfull_count", rx_count,    DEPTH);
        chk("lit_rxfull_ovf",   rx_overflow, 1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("lit_rxfull_order", rx_data, i + 1);
            rx_pop();
        end
        chk("lit_rxfull_drained", rx_valid, 0);
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        chk("lit_rx_ovf_clear", rx_overflow, 0);

        // Full RX with simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++) rx_byte(8'(i + 1));
        chk("lit_sim_pre_count", rx_count, DEPTH);
        core_rx_data = 8'hEE;
        core_rx_stb  = 1'b1;
        rx_ack       = 1'b1;
        tick(1);
        core_rx_stb = 1'b0;
        rx_ack      = 1'b0;
        tick(1);
        chk("lit_sim_count", rx_count,    DEPTH);
        chk("lit_sim_ovf",   rx_overflow, 0);
        chk("lit_sim_head",  rx_data,     2);
        last = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            last = rx_data;
            rx_pop();
        end
        chk("lit_sim_tail", last, 8'hEE);
        chk("lit_sim_empty", rx_valid, 0);

        // TX: two bytes, core acks after a hold period.
        tx_data  = 8'h10;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        chk("lit_tx_stb_wait", core_tx_stb, 0);
        tick(1);
        chk("lit_tx_stb_rise", core_tx_stb, 1);
        chk("lit_tx_data0",    core_tx_data, 8'h10);
        tx_data  = 8'h20;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("lit_tx_hold_stb",  core_tx_stb,  1);
            chk("lit_tx_hold_data", core_tx_data, 8'h10);
            tick(1);
        end
        core_tx_ack = 1'b1;
        tick(1);
        core_tx_ack = 1'b0;
        chk("lit_tx_gap", core_tx_stb, 0);
        found = 0;
        for (int i = 0; i < 4 && !found; i++) begin
            tick(1);
            found = core_tx_stb;
        end
        chk("lit_tx_second_req", found, 1);
        chk("lit_tx_data1", core_tx_data, 8'h20);
        for (int i = 0; i < 5; i++) begin
            chk("lit_tx_hold2", core_tx_stb, 1);
            tick(1);
        end
        core_tx_ack = 1'b1;
        tick(1);
        core_tx_ack = 1'b0;
        tick(3);
        chk("lit_tx_idle", core_tx_stb, 0);

        // TX fill to DEPTH with no acks, then one extra write.
        for (int i = 0; i < DEPTH - 1; i++) tx_write(8'(i + 1));
        chk("lit_txfill_ready_before", tx_ready, 1);
        tx_write(8'(DEPTH));
        chk("lit_txfill_ready", tx_ready, 0);
        chk("lit_txfill_noovf", tx_overflow, 0);
        tx_write(8'hFF);
        chk("lit_txfill_ovf", tx_overflow, 1);
        core_tx_ack = 1'b1;
        tick(1);
        core_tx_ack = 1'b0;
        chk("lit_txfill_ready_again", tx_ready, 1);
        core_tx_ack = 1'b1;
        tick(4 * DEPTH + 8);
        core_tx_ack = 1'b0;
        tick(2);
        chk("lit_txfill_drained", core_tx_stb, 0);
        chk("lit_txfill_lastbyte", core_tx_data, DEPTH);
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        chk("lit_tx_ovf_clear", tx_overflow, 0);

        // Reset during an outstanding request with bytes queued.
        rx_byte(8'h55);
        tx_write(8'hA1); tx_write(8'hA2); tx_write(8'hA3);
        chk("lit_rst_pre_stb", core_tx_stb, 1);
        chk("lit_rst_pre_rxv", rx_valid, 1);
        RESET = 1'b1;
        tick(1);
        chk("lit_rst_stb",   core_tx_stb, 0);
        chk("lit_rst_ready", tx_ready,    1);
        chk("lit_rst_rxv",   rx_valid,    0);
        RESET = 1'b0;
        core_tx_ack = 1'b1;
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (core_tx_stb) hits++;
        end
        core_tx_ack = 1'b0;
        chk("lit_rst_no_tx", hits, 0);

        // Randomized traffic: fill-biased first half, drain-biased second half.
        for (int c = 0; c < 3000; c++) begin
            RESET        = ($urandom_range(0, 599) == 0);
            core_rx_data = 8'($urandom);
            core_rx_stb  = 1'($urandom);
            tx_data      = 8'($urandom);
            tx_valid     = 1'($urandom);
            rx_ack       = ($urandom_range(0, 3) < ((c < 1500) ? 1 : 3));
            core_tx_ack  = ($urandom_range(0, 2) == 0);
            clear_flags  = ($urandom_range(0, 49) == 0);
            tick(1);
        end
        RESET = 1'b0; core_rx_stb = 1'b0; tx_valid = 1'b0;
        rx_ack = 1'b0; core_tx_ack = 1'b0; clear_flags = 1'b0;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
